// File: rtl/ps2_scan_decoder.sv
// Turns the PS/2 Set-2 byte stream into single key events (code, make/break, extended).
// Prefixes are stripped, status and fake-shift bytes dropped, and stalled sequences abandoned.
module ps2_scan_decoder #(
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    output logic [7:0] key_code,
    output logic       key_pressed,
    output logic       key_extended,
    output logic       code_valid_tick
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        PAUSE
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       skip_cnt, skip_nxt;
    logic [CNT_W-1:0] idle_cnt, idle_nxt;
    logic             timeout;
    logic             emit, emit_make, emit_ext;

    function automatic logic is_status(input logic [7:0] b);
        return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == 8'h12) || (b == 8'h59);
    endfunction

    assign timeout = (state != IDLE) && (idle_cnt == CNT_W'(TIMEOUT_CYCLES));

    // A byte arriving on the expiry cycle takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        emit      = 1'b0;
        emit_make = 1'b0;
        emit_ext  = 1'b0;
        if (rx_done_tick) begin
            case (state)
                IDLE: begin
                    if (rx_data == 8'hE0) begin
                        state_nxt = EXT;
                    end else if (rx_data == 8'hF0) begin
                        state_nxt = BRK;
                    end else if (rx_data == 8'hE1) begin
                        state_nxt = PAUSE;
                        skip_nxt  = 3'd7;
                    end else if (!is_status(rx_data)) begin
                        emit      = 1'b1;
                        emit_make = 1'b1;
                    end
                end
                EXT: begin
                    if (rx_data == 8'hF0) begin
                        state_nxt = EXT_BRK;
                    end else if (rx_data == 8'hE0) begin
                        state_nxt = EXT;
                    end else if (is_fake_shift(rx_data)) begin
                        state_nxt = IDLE;
                    end else begin
                        emit      = 1'b1;
                        emit_make = 1'b1;
                        emit_ext  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                BRK: begin
                    if (rx_data != 8'hF0) begin
                        emit      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                EXT_BRK: begin
                    state_nxt = IDLE;
                    if (!is_fake_shift(rx_data)) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                    end
                end
                PAUSE: begin
                    skip_nxt = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1) begin
                        skip_nxt  = 3'd0;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (timeout) begin
            state_nxt = IDLE;
            skip_nxt  = 3'd0;
        end
    end

    always_comb begin
        idle_nxt = idle_cnt + CNT_W'(1);
        if (rx_done_tick || (state == IDLE) || timeout) begin
            idle_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            skip_cnt        <= 3'd0;
            idle_cnt        <= '0;
            key_code        <= 8'h00;
            key_pressed     <= 1'b0;
            key_extended    <= 1'b0;
            code_valid_tick <= 1'b0;
        end else begin
            state           <= state_nxt;
            skip_cnt        <= skip_nxt;
            idle_cnt        <= idle_nxt;
            code_valid_tick <= emit;
            if (emit) begin
                key_code     <= rx_data;
                key_pressed  <= emit_make;
                key_extended <= emit_ext;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: directed sequences plus random byte streams
// against a prefix-list reference model.
module tb_ps2_scan_decoder;

    localparam int T = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done_tick = 1'b0;
    logic [7:0] key_code;
    logic       key_pressed;
    logic       key_extended;
    logic       code_valid_tick;

    ps2_scan_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_done_tick(rx_done_tick),
        .key_code(key_code),
        .key_pressed(key_pressed),
        .key_extended(key_extended),
        .code_valid_tick(code_valid_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  code;
        logic        pressed;
        logic        ext;
        logic [31:0] cyc;
    } ev_t;

    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   ev_seen = 0;
    ev_t  exp_q[$];
    ev_t  held = '0;

    // reference model state: prefixes collected so far, pause bytes still to skip
    logic [7:0] pend[$];
    int         pause_left = 0;
    int         last_tick = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic pend_has(input logic [7:0] b);
        foreach (pend[i]) if (pend[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_clear();
        pend.delete();
        pause_left = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic ext, brk;
        ev_t  e;
        if (cyc - last_tick - 1 > T) model_clear();
        last_tick = cyc;
        if (pause_left > 0) begin
            pause_left--;
            return;
        end
        ext = pend_has(8'hE0);
        brk = pend_has(8'hF0);
        if (pend.size() == 0 && b == 8'hE1) begin
            pause_left = 7;
        end else if (b == 8'hF0 && !(ext && brk)) begin
            pend.push_back(b);
        end else if (b == 8'hE0 && !brk) begin
            pend.push_back(b);
        end else if (pend.size() == 0 && (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
            // controller/status byte: dropped
        end else if (ext && (b == 8'h12 || b == 8'h59)) begin
            model_clear();
        end else begin
            e.code    = b;
            e.pressed = !brk;
            e.ext     = ext;
            e.cyc     = 32'(cyc + 1);
            exp_q.push_back(e);
            model_clear();
        end
    endfunction

    // monitor: pops the expected event on every valid pulse, otherwise checks held outputs
    always @(negedge clk) begin
        ev_t e;
        if (!reset) begin
            compared++;
            if (key_code !== 8'h00 || key_pressed !== 1'b0 || key_extended !== 1'b0 || code_valid_tick !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_outputs: got code=%h p=%b x=%b v=%b, want 00 0 0 0",
                         key_code, key_pressed, key_extended, code_valid_tick);
            end
            held = '0;
        end else begin
            while (exp_q.size() > 0 && int'(exp_q[0].cyc) < cyc) begin
                e = exp_q.pop_front();
                compared++;
                mismatched++;
                $display("FAIL missing_event: no pulse at cycle %0d, want code=%h p=%b x=%b",
                         e.cyc, e.code, e.pressed, e.ext);
            end
            if (code_valid_tick) begin
                ev_seen++;
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_event: got code=%h p=%b x=%b at cycle %0d, want none",
                             key_code, key_pressed, key_extended, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (key_code !== e.code || key_pressed !== e.pressed || key_extended !== e.ext ||
                        int'(e.cyc) != cyc) begin
                        mismatched++;
                        $display("FAIL event: got code=%h p=%b x=%b cyc=%0d, want code=%h p=%b x=%b cyc=%0d",
                                 key_code, key_pressed, key_extended, cyc, e.code, e.pressed, e.ext, e.cyc);
                    end
                    held = e;
                end
            end else begin
                compared++;
                if (key_code !== held.code || key_pressed !== held.pressed || key_extended !== held.ext) begin
                    mismatched++;
                    $display("FAIL held_outputs: got code=%h p=%b x=%b, want code=%h p=%b x=%b",
                             key_code, key_pressed, key_extended, held.code, held.pressed, held.ext);
                end
            end
        end
    end

    task automatic step(input logic tick, input logic [7:0] b);
        rx_done_tick = tick;
        rx_data      = tick ? b : 8'($urandom);
        if (tick) model_byte(b);
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) step(1'b0, 8'h00);
        step(1'b1, b);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    task automatic check_held(input string name, input logic [7:0] code, input logic p, input logic x);
        compared++;
        if (key_code !== code || key_pressed !== p || key_extended !== x) begin
            mismatched++;
            $display("FAIL %s: got code=%h p=%b x=%b, want code=%h p=%b x=%b",
                     name, key_code, key_pressed, key_extended, code, p, x);
        end
    endtask

    task automatic check_events(input string name, input int mark, input int n);
        compared++;
        if (ev_seen - mark != n) begin
            mismatched++;
            $display("FAIL %s: got %0d events, want %0d", name, ev_seen - mark, n);
        end
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check_held("reset_mid_seq", 8'h00, 1'b0, 1'b0);
        #2 reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int mark;
        int r;
        logic [7:0] b;
        logic [7:0] pause_seq [8];
        logic [7:0] status_seq [4];
        pause_seq  = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        status_seq = '{8'hAA, 8'hFA, 8'h00, 8'hFF};

        repeat (3) @(negedge clk);
        check_held("reset_state", 8'h00, 1'b0, 1'b0);
        #2 reset = 1'b1;
        @(negedge clk);

        mark = ev_seen;
        send(8'h1D, 20);
        idle(1);
        check_held("make_1d", 8'h1D, 1'b1, 1'b0);
        send(8'hF0, 20);
        send(8'h1D, 20);
        idle(3);
        check_held("break_1d", 8'h1D, 1'b0, 1'b0);
        check_events("count_1d", mark, 2);

        mark = ev_seen;
        send(8'hE0, 2); send(8'h5A, 2);
        idle(2);
        check_held("ext_make_5a", 8'h5A, 1'b1, 1'b1);
        send(8'hE0, 2); send(8'hF0, 0); send(8'h5A, 0);
        idle(3);
        check_held("ext_break_5a", 8'h5A, 1'b0, 1'b1);
        check_events("count_5a", mark, 2);

        mark = ev_seen;
        send(8'hE0, 1); send(8'h12, 0); send(8'hE0, 0); send(8'h7C, 0);
        idle(3);
        check_held("prtscr", 8'h7C, 1'b1, 1'b1);
        check_events("count_prtscr", mark, 1);

        mark = ev_seen;
        foreach (pause_seq[i]) send(pause_seq[i], (i % 2));
        idle(3);
        check_events("count_pause", mark, 0);
        send(8'h1B, 1);
        idle(3);
        check_held("after_pause", 8'h1B, 1'b1, 1'b0);

        send(8'hF0, 2);
        send(8'h1B, T + 1);
        idle(3);
        check_held("timeout_make", 8'h1B, 1'b1, 1'b0);
        send(8'hF0, 2);
        send(8'h1B, T);
        idle(3);
        check_held("expiry_break", 8'h1B, 1'b0, 1'b0);

        send(8'hE0, 2); send(8'hF0, 0);
        idle(2);
        do_reset();
        send(8'h42, 1);
        idle(3);
        check_held("after_reset", 8'h42, 1'b1, 1'b0);

        mark = ev_seen;
        foreach (status_seq[i]) send(status_seq[i], i);
        idle(3);
        check_events("count_status", mark, 0);
        check_held("status_held", 8'h42, 1'b1, 1'b0);

        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 10)      b = 8'hE0;
            else if (r < 20) b = 8'hF0;
            else if (r < 23) b = 8'hE1;
            else if (r < 30) b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
            else if (r < 38) b = status_seq[$urandom_range(0, 3)];
            else             b = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 99);
            if (r < 60)      send(b, 0);
            else if (r < 90) send(b, $urandom_range(1, 4));
            else             send(b, $urandom_range(T - 2, T + 2));
        end
        idle(T + 5);

        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d events outstanding, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
